// File: rtl/mem_data_resp.sv
// MEM-stage response endpoint for the data SRAM-like interface: tracks outstanding
// requests, drops responses of cancelled/flushed instructions, and holds one response for a stalled WB.
module mem_data_resp #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int CNT_W           = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             exe_req_fire,
   input  logic             exe_req_cancel,
   input  logic             flush,
   input  logic             data_sram_data_ok,
   input  logic [31:0]      data_sram_rdata,
   input  logic             mem_valid,
   input  logic             wb_allow_in,
   output logic             mem_data_ok,
   output logic [31:0]      mem_rdata,
   output logic [CNT_W-1:0] outstanding,
   output logic             ex_block_req,
   output logic             resp_overrun
);

   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   logic [CNT_W-1:0] outstanding_r;
   logic [CNT_W-1:0] cancel_cnt_r;
   logic             buf_valid_r;
   logic [31:0]      buf_data_r;
   logic             resp_overrun_r;

   logic [CNT_W-1:0] outstanding_next_s;
   logic [CNT_W-1:0] cancel_cnt_next_s;
   logic             buf_valid_next_s;
   logic [31:0]      buf_data_next_s;
   logic             cnt_err_s;
   logic             buf_err_s;
   logic             discard_s;
   logic             live_s;
   logic             wb_take_s;

   // Outstanding counter next value with saturation at both ends
   always_comb begin
      outstanding_next_s = outstanding_r;
      cnt_err_s          = 1'b0;
      case ({exe_req_fire, data_sram_data_ok})
         2'b10: begin
            if (outstanding_r == MAX_CNT) begin
               cnt_err_s = 1'b1;
            end else begin
               outstanding_next_s = outstanding_r + ONE_CNT;
            end
         end
         2'b01: begin
            if (outstanding_r == ZERO_CNT) begin
               cnt_err_s = 1'b1;
            end else begin
               outstanding_next_s = outstanding_r - ONE_CNT;
            end
         end
         default: begin
            outstanding_next_s = outstanding_r;
         end
      endcase
   end

   // Cancel counter: a flush discards everything still owed after this cycle
   always_comb begin
      cancel_cnt_next_s = cancel_cnt_r;
      if (flush) begin
         cancel_cnt_next_s = outstanding_next_s;
      end else begin
         cancel_cnt_next_s = cancel_cnt_r
                           + CNT_W'(exe_req_fire & exe_req_cancel)
                           - CNT_W'(data_sram_data_ok & (cancel_cnt_r != ZERO_CNT));
      end
   end

   // Response classification and one-entry buffer control
   always_comb begin
      discard_s        = (cancel_cnt_r != ZERO_CNT) | flush;
      live_s           = data_sram_data_ok & ~discard_s;
      wb_take_s        = mem_valid & wb_allow_in;
      buf_valid_next_s = buf_valid_r;
      buf_data_next_s  = buf_data_r;
      buf_err_s        = live_s & buf_valid_r;
      if (flush) begin
         buf_valid_next_s = 1'b0;
      end else if (buf_valid_r) begin
         // A second live response cannot be held; the older one wins
         if (wb_take_s) begin
            buf_valid_next_s = 1'b0;
         end else begin
            buf_valid_next_s = 1'b1;
         end
      end else if (live_s & ~wb_take_s) begin
         buf_valid_next_s = 1'b1;
         buf_data_next_s  = data_sram_rdata;
      end else begin
         buf_valid_next_s = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         outstanding_r  <= ZERO_CNT;
         cancel_cnt_r   <= ZERO_CNT;
         buf_valid_r    <= 1'b0;
         buf_data_r     <= 32'h0000_0000;
         resp_overrun_r <= 1'b0;
      end else begin
         outstanding_r  <= outstanding_next_s;
         cancel_cnt_r   <= cancel_cnt_next_s;
         buf_valid_r    <= buf_valid_next_s;
         buf_data_r     <= buf_data_next_s;
         resp_overrun_r <= resp_overrun_r | cnt_err_s | buf_err_s;
      end
   end

   // Outputs; the response path is combinational for zero-latency pass-through
   always_comb begin
      mem_data_ok  = mem_valid & ~flush & (buf_valid_r | live_s);
      mem_rdata    = buf_valid_r ? buf_data_r : data_sram_rdata;
      outstanding  = outstanding_r;
      ex_block_req = (outstanding_r == MAX_CNT);
      resp_overrun = resp_overrun_r;
   end

endmodule

// File: doc/mem_data_resp.md
# mem_data_resp

Response-side endpoint for the data SRAM-like interface in the 5-stage pipeline. The EXE stage issues load/store requests and completes the address handshake. This block sits in the MEM stage and tracks outstanding requests. It drops responses that belong to cancelled or flushed instructions. When WB cannot accept a response yet, it buffers that one response so MEM sees a stable `mem_data_ok`/`mem_rdata` pair.

## Interface
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests (1..3)
- CNT_W, 2, width of the outstanding and cancel counters; must hold MAX_OUTSTANDING
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- exe_req_fire  in  1  EXE request accepted this cycle (req & addr_ok)
- exe_req_cancel  in  1  accepted request belongs to an instruction already marked need_cancel; qualified by exe_req_fire
- flush  in  1  wb_ex | wb_is_ertn; kills every in-flight memory instruction
- data_sram_data_ok  in  1  one response (read or write) returns this cycle, in request order
- data_sram_rdata  in  32  read data, valid with data_ok
- mem_valid  in  1  MEM holds a live memory instruction waiting for its response
- wb_allow_in  in  1  WB accepts MEM's instruction this cycle
- mem_data_ok  out  1  response for MEM's current instruction is available
- mem_rdata  out  32  read data for MEM's current instruction
- outstanding  out  CNT_W  requests accepted and not yet answered
- ex_block_req  out  1  EXE must not fire a new request this cycle
- resp_overrun  out  1  sticky protocol-error flag

## Operation
- Outstanding counter:
  - +1 on exe_req_fire, -1 on data_ok; both in the same cycle leaves it unchanged.
  - Never wraps. An increment at MAX with no data_ok saturates the counter and sets resp_overrun. A decrement at 0 also sets resp_overrun.
- ex_block_req = (outstanding == MAX_OUTSTANDING); registered-state based.
- Cancel counter (cancel_cnt): number of future responses to discard.
  - On flush: cancel_cnt <= outstanding_next, the value the outstanding counter takes this cycle, including a same-cycle fire and data_ok.
  - Otherwise: cancel_cnt <= cancel_cnt + (exe_req_fire & exe_req_cancel) - (data_ok & cancel_cnt != 0).
- Response classification:
  - Discarded if cancel_cnt != 0, or if flush is high in the same cycle.
  - Otherwise it is live.
- Live response handling:
  - If mem_valid & wb_allow_in: pass through combinationally; nothing is stored.
  - Else: capture into the one-entry buffer (buf_valid <= 1, buf_data <= rdata).
  - If a live response arrives while buf_valid = 1: keep the old buffer contents and set resp_overrun.
- Buffer release: buf_valid clears when mem_valid & wb_allow_in & buf_valid, or on flush.
- Outputs:
  - mem_data_ok = mem_valid & !flush & (buf_valid | live data_ok).
  - mem_rdata = buf_valid ? buf_data : data_sram_rdata. Its value is don't-care when mem_data_ok = 0, but it must not be X after reset.
- Store responses go through the same path; MEM ignores mem_rdata for stores.
- resp_overrun clears only on reset.

## Timing
- Reset, asynchronous, while rst = 0: outstanding = 0, cancel_cnt = 0, buf_valid = 0, buf_data = 0, resp_overrun = 0. Consequently mem_data_ok = 0, ex_block_req = 0, mem_rdata = data_sram_rdata.
- Reset mid-transaction: all counts are lost. The memory side is reset by the same rst, so stale data_ok cannot arrive.
- Latency:
  - A live response with WB ready: mem_data_ok in the same cycle as data_ok (0 cycles).
  - A buffered response: mem_data_ok held from the next cycle until WB accepts.
- Flush priority: flush overrides buffer capture and pass-through. mem_data_ok is 0 in the flush cycle.
- Simultaneous flush + fire + data_ok: outstanding_next = outstanding; cancel_cnt = outstanding_next; no buffer capture.
- Counter updates and the buffer write take effect at the rising edge. ex_block_req changes only after an edge.

## Test plan
- Reset and back-to-back loads:
  - Stimulus: rst low, then release. Two fires on consecutive cycles; data_ok on cycles 3 and 4 with rdata 0x11111111 then 0x22222222; mem_valid & wb_allow_in held at 1.
  - Required: outstanding goes 0→1→2→1→0. ex_block_req = 1 only while outstanding = 2. mem_data_ok pulses in both data_ok cycles with matching data.
- WB stall:
  - Stimulus: fire; data_ok with rdata 0xDEADBEEF while wb_allow_in = 0, held 0 for 3 cycles, then 1.
  - Required: mem_data_ok = 1 for 4 cycles, mem_rdata = 0xDEADBEEF throughout; buf_valid clears after the accept edge.
- Flush with 2 outstanding:
  - Stimulus: 2 fires, then flush for 1 cycle; then 2 data_ok with mem_valid = 1.
  - Required: cancel_cnt = 2 after the flush. mem_data_ok stays 0 for both responses. outstanding and cancel_cnt return to 0.
- Same-cycle events:
  - Stimulus: with outstanding = 1 and cancel_cnt = 0, assert flush, fire and data_ok together.
  - Required: outstanding stays 1, cancel_cnt = 1, mem_data_ok = 0, no buffer capture. The next data_ok is discarded.
- Cancelled request:
  - Stimulus: fire with exe_req_cancel = 1, then a normal fire; data_ok returns 0xAAAA0000 then 0x0000BBBB.
  - Required: the first response is discarded; mem_data_ok shows only 0x0000BBBB.
- Protocol errors:
  - Stimulus: data_ok with outstanding = 0. Separately, a third fire at MAX = 2 with no data_ok.
  - Required: resp_overrun sets and stays 1 until rst; counters neither wrap nor underflow.
